// File: rtl/alu_pkg.sv
// rtl/alu_pkg.sv - shared widths, stage-1 register bundle and nibble g/p cell
package alu_pkg;

    localparam int WIDTH = 16;
    localparam int NIB   = 4;
    localparam int NGRP  = 4;

    typedef struct packed {
        logic [WIDTH-1:0] a;
        logic [WIDTH-1:0] b_eff;
        logic [WIDTH-1:0] g;
        logic [WIDTH-1:0] p;
        logic [NGRP-1:0]  grp_g;
        logic [NGRP-1:0]  grp_p;
        logic             c0;
    } s1_t;

    // Nibble generate/propagate: returns {G, P}
    function automatic logic [1:0] gp4(input logic [NIB-1:0] g, input logic [NIB-1:0] p);
        logic grp_g;
        logic grp_p;
        grp_g = g[3] | (p[3] & g[2]) | (p[3] & p[2] & g[1]) | (p[3] & p[2] & p[1] & g[0]);
        grp_p = &p;
        return {grp_g, grp_p};
    endfunction

endpackage

// File: rtl/cla_carry4.sv
// rtl/cla_carry4.sv - four-term full carry lookahead, c[0] is carry into position 1
module cla_carry4 (
    input  logic [3:0] g,
    input  logic [3:0] p,
    input  logic       c0,
    output logic [3:0] c
);

    assign c[0] = g[0] | (p[0] & c0);
    assign c[1] = g[1] | (p[1] & g[0]) | (p[1] & p[0] & c0);
    assign c[2] = g[2] | (p[2] & g[1]) | (p[2] & p[1] & g[0]) | (p[2] & p[1] & p[0] & c0);
    assign c[3] = g[3] | (p[3] & g[2]) | (p[3] & p[2] & g[1]) | (p[3] & p[2] & p[1] & g[0])
                | (p[3] & p[2] & p[1] & p[0] & c0);

endmodule

// File: rtl/cla16_pipe_addsub.sv
// rtl/cla16_pipe_addsub.sv - two-stage pipelined 16-bit CLA adder/subtractor with valid/ready
module cla16_pipe_addsub
    import alu_pkg::*;
(
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             sub,
    input  logic             cin,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] sum,
    output logic             cout,
    output logic             ofl,
    output logic             zero
);

    logic s1_valid;
    logic s2_load;
    logic s1_adv;
    logic accept;
    s1_t  s1_d;
    s1_t  s1_q;

    assign s2_load  = !out_valid || out_ready;
    assign s1_adv   = s1_valid && s2_load;
    assign in_ready = !s1_valid || s2_load;
    assign accept   = in_valid && in_ready;

    always_comb begin
        s1_d.a     = a;
        s1_d.b_eff = sub ? ~b : b;
        s1_d.c0    = sub | cin;
        s1_d.g     = a & s1_d.b_eff;
        s1_d.p     = a | s1_d.b_eff;
        s1_d.grp_g = '0;
        s1_d.grp_p = '0;
        for (int k = 0; k < NGRP; k++) begin
            {s1_d.grp_g[k], s1_d.grp_p[k]} = gp4(s1_d.g[k*NIB +: NIB], s1_d.p[k*NIB +: NIB]);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            s1_valid <= 1'b0;
            s1_q     <= '0;
        end else if (accept) begin
            s1_valid <= 1'b1;
            s1_q     <= s1_d;
        end else if (s1_adv) begin
            s1_valid <= 1'b0;
        end
    end

    logic [NGRP-1:0] grp_c;
    logic [NGRP-1:0] nib_cin;
    logic [WIDTH:0]  c;

    cla_carry4 u_grp (
        .g  (s1_q.grp_g),
        .p  (s1_q.grp_p),
        .c0 (s1_q.c0),
        .c  (grp_c)
    );

    assign nib_cin = {grp_c[2:0], s1_q.c0};
    assign c[0]    = s1_q.c0;

    // Each nibble also regenerates its own carry-out; c[16] equals grp_c[3]
    for (genvar k = 0; k < NGRP; k++) begin : g_nib
        cla_carry4 u_nib (
            .g  (s1_q.g[k*NIB +: NIB]),
            .p  (s1_q.p[k*NIB +: NIB]),
            .c0 (nib_cin[k]),
            .c  (c[k*NIB+1 +: NIB])
        );
    end

    logic [WIDTH-1:0] sum_d;
    assign sum_d = s1_q.a ^ s1_q.b_eff ^ c[WIDTH-1:0];

    always_ff @(posedge clk) begin
        if (rst) begin
            out_valid <= 1'b0;
            sum       <= '0;
            cout      <= 1'b0;
            ofl       <= 1'b0;
            zero      <= 1'b0;
        end else if (s2_load) begin
            out_valid <= s1_valid;
            if (s1_valid) begin
                sum  <= sum_d;
                cout <= grp_c[3];
                ofl  <= c[WIDTH] ^ c[WIDTH-1];
                zero <= ~|sum_d;
            end
        end
    end

endmodule
